// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared constants and FSM state type for the ADC capture buffer.
// Optional averaging is selected with ADC_CAPTURE_AVG_EN.
package adc_capture_pkg;

  localparam int DEPTH_DEF  = 10000;
  localparam int DATA_W_DEF = 12;
  localparam int ADDR_W_DEF = 14;
  localparam int OUT_W      = 16;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    READY,
    READOUT
  } cap_state_t;

endpackage

// File: rtl/adc_capture_ram.sv
// adc_capture_ram: simple dual-port sample RAM, one write port,
// registered read port whose output register is cleared by reset.
module adc_capture_ram #(
  parameter int DEPTH  = 10000,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 14
) (
  input  logic              DCLK,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              re,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_q
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge DCLK) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge DCLK or negedge rst_n) begin
    if (!rst_n) rd_q <= '0;
    else if (re) rd_q <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_capture_buffer.sv
// adc_capture_buffer: triggered burst capture of ADC samples, then word-per-request readout.
// Define ADC_CAPTURE_AVG_EN to store block averages of 2^AVG_LOG2 samples.
module adc_capture_buffer
  import adc_capture_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
`ifdef ADC_CAPTURE_AVG_EN
  , parameter int AVG_LOG2 = 2
`endif
) (
  input  logic              DCLK,
  input  logic              rst_n,
  input  logic              START_FGPA,
  input  logic [DATA_W-1:0] adc_data,
  input  logic              adc_valid,
  input  logic              rd_req,
  output logic [OUT_W-1:0]  rd_data,
  output logic              rd_valid,
  output logic              busy,
  output logic              ready,
  output logic              capture_done,
  output logic [ADDR_W-1:0] wr_count
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  cap_state_t state_q, state_d;

  logic [1:0]        start_sync;
  logic              start_prev;
  logic              trig;
  logic              start_cap;
  logic              rd_acc;
  logic              rd_last;
  logic              we;
  logic              wr_last;
  logic              store_en;
  logic [DATA_W-1:0] store_data;
  logic [DATA_W-1:0] rd_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [ADDR_W-1:0] rd_addr_q;

  always_ff @(posedge DCLK or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      start_prev <= 1'b0;
    end else begin
      start_sync <= {start_sync[0], START_FGPA};
      start_prev <= start_sync[1];
    end
  end

  assign trig = start_sync[1] & ~start_prev;

`ifdef ADC_CAPTURE_AVG_EN
  localparam int ACC_W = DATA_W + AVG_LOG2;

  logic [ACC_W-1:0]    acc_q;
  logic [ACC_W-1:0]    acc_sum;
  logic [AVG_LOG2-1:0] avg_cnt_q;

  assign acc_sum    = acc_q + ACC_W'(adc_data);
  assign store_en   = adc_valid & (&avg_cnt_q);
  assign store_data = acc_sum[ACC_W-1:AVG_LOG2];

  always_ff @(posedge DCLK or negedge rst_n) begin
    if (!rst_n) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else if (start_cap) begin
      acc_q     <= '0;
      avg_cnt_q <= '0;
    end else if (state_q == CAPTURE && adc_valid) begin
      acc_q     <= (&avg_cnt_q) ? '0 : acc_sum;
      avg_cnt_q <= avg_cnt_q + 1'b1;
    end
  end
`else
  assign store_en   = adc_valid;
  assign store_data = adc_data;
`endif

  assign we      = (state_q == CAPTURE) & store_en;
  assign wr_last = we & (wr_addr_q == LAST);
  assign rd_last = (rd_addr_q == LAST);

  // Trigger outranks a same-cycle read in READY.
  always_comb begin
    state_d   = state_q;
    start_cap = 1'b0;
    rd_acc    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (trig) begin
          state_d   = CAPTURE;
          start_cap = 1'b1;
        end
      end
      CAPTURE: begin
        if (wr_last) state_d = READY;
      end
      READY: begin
        if (trig) begin
          state_d   = CAPTURE;
          start_cap = 1'b1;
        end else if (rd_req) begin
          rd_acc  = 1'b1;
          state_d = rd_last ? IDLE : READOUT;
        end
      end
      READOUT: begin
        if (rd_req) begin
          rd_acc = 1'b1;
          if (rd_last) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge DCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wr_addr_q    <= '0;
      rd_addr_q    <= '0;
      capture_done <= 1'b0;
      rd_valid     <= 1'b0;
    end else begin
      state_q      <= state_d;
      capture_done <= wr_last;
      rd_valid     <= rd_acc;
      if (start_cap) wr_addr_q <= '0;
      else if (we) wr_addr_q <= wr_addr_q + 1'b1;
      if (start_cap) rd_addr_q <= '0;
      else if (rd_acc) rd_addr_q <= rd_addr_q + 1'b1;
    end
  end

  adc_capture_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .DCLK    (DCLK),
    .rst_n   (rst_n),
    .we      (we),
    .wr_addr (wr_addr_q),
    .wr_data (store_data),
    .re      (rd_acc),
    .rd_addr (rd_addr_q),
    .rd_q    (rd_q)
  );

  assign rd_data  = {{(OUT_W - DATA_W){1'b0}}, rd_q};
  assign wr_count = wr_addr_q;
  assign busy     = (state_q == CAPTURE);
  assign ready    = (state_q == READY) | (state_q == READOUT);

endmodule

// File: tb/tb_adc_capture_buffer.sv
// tb_adc_capture_buffer: directed self-checking bench for adc_capture_buffer.
// Inputs change on the falling edge; outputs are observed on the falling edge.
module tb_adc_capture_buffer;

  localparam int DEPTH  = 10000;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 14;

  logic              DCLK = 1'b0;
  logic              rst_n = 1'b0;
  logic              START_FGPA = 1'b0;
  logic [DATA_W-1:0] adc_data = '0;
  logic              adc_valid = 1'b0;
  logic              rd_req = 1'b0;
  logic [15:0]       rd_data;
  logic              rd_valid;
  logic              busy;
  logic              ready;
  logic              capture_done;
  logic [ADDR_W-1:0] wr_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [DATA_W-1:0] model [DEPTH];

  always #5 DCLK = ~DCLK;

  adc_capture_buffer #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .DCLK         (DCLK),
    .rst_n        (rst_n),
    .START_FGPA   (START_FGPA),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .busy         (busy),
    .ready        (ready),
    .capture_done (capture_done),
    .wr_count     (wr_count)
  );

  // Raise START_FGPA and return on the first falling edge with busy high.
  task automatic trigger();
    int t;
    t = 0;
    START_FGPA = 1'b1;
    @(negedge DCLK);
    while (!busy && t < 8) begin
      @(negedge DCLK);
      t++;
    end
    START_FGPA = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_err++;
      $display("FAIL trigger_busy: got %b exp 1 (timeout)", busy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge DCLK);
    n_cmp++;
    if ({rd_data, rd_valid, busy, ready, capture_done, wr_count} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_init: got %h exp 0",
               {rd_data, rd_valid, busy, ready, capture_done, wr_count});
    end
    rst_n = 1'b1;
    @(negedge DCLK);
    trigger();
    for (int k = 0; k < 100; k++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(k + 1);
      @(negedge DCLK);
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (wr_count !== 14'd100 || busy !== 1'b1) begin
      n_err++;
      $display("FAIL reset_pre: got wr_count=%0d busy=%b exp 100 1", wr_count, busy);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rd_data, rd_valid, busy, ready, capture_done, wr_count} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_async: got %h exp 0",
               {rd_data, rd_valid, busy, ready, capture_done, wr_count});
    end
    @(negedge DCLK);
    rst_n = 1'b1;
    @(negedge DCLK);
    n_cmp++;
    if ({rd_data, rd_valid, busy, ready, capture_done, wr_count} !== 34'd0) begin
      n_err++;
      $display("FAIL reset_release: got %h exp 0",
               {rd_data, rd_valid, busy, ready, capture_done, wr_count});
    end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      @(negedge DCLK);
      rd_req = 1'b0;
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_err++;
        $display("FAIL reset_rd_ignored: got rd_valid=%b exp 0", rd_valid);
      end
      @(negedge DCLK);
    end
  endtask

`ifndef ADC_CAPTURE_AVG_EN
  task automatic test_ramp();
    int done_cnt;
    done_cnt = 0;
    trigger();
    for (int k = 0; k < DEPTH; k++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(k);
      model[k]  = 12'(k);
      @(negedge DCLK);
      if (capture_done === 1'b1) done_cnt++;
      if (k == 499) begin
        n_cmp++;
        if (wr_count !== 14'd500) begin
          n_err++;
          $display("FAIL ramp_wr_count_mid: got %0d exp 500", wr_count);
        end
      end
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (done_cnt != 1 || capture_done !== 1'b1 || ready !== 1'b1 ||
        busy !== 1'b0 || wr_count !== 14'd10000) begin
      n_err++;
      $display("FAIL ramp_done: got pulses=%0d done=%b ready=%b busy=%b wr_count=%0d exp 1 1 1 0 10000",
               done_cnt, capture_done, ready, busy, wr_count);
    end
    @(negedge DCLK);
    n_cmp++;
    if (capture_done !== 1'b0) begin
      n_err++;
      $display("FAIL ramp_done_pulse: got %b exp 0", capture_done);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 1'b1;
      @(negedge DCLK);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== {4'b0, model[i]}) begin
        n_err++;
        $display("FAIL ramp_read[%0d]: got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, {4'b0, model[i]});
      end
    end
    rd_req = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL ramp_ready_drop: got %b exp 0", ready);
    end
    @(negedge DCLK);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h070F) begin
      n_err++;
      $display("FAIL ramp_hold: got v=%b d=%h exp 0 070f", rd_valid, rd_data);
    end
    rd_req = 1'b1;
    @(negedge DCLK);
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_rd_ignored: got %b exp 0", rd_valid);
    end
  endtask

  task automatic test_trigger();
    int done_cnt;
    done_cnt = 0;
    trigger();
    for (int k = 0; k < DEPTH; k++) begin
      if (k == 500) START_FGPA = 1'b1;
      if (k == 600) START_FGPA = 1'b0;
      adc_valid = 1'b1;
      adc_data  = 12'(k + 100);
      @(negedge DCLK);
      if (capture_done === 1'b1) done_cnt++;
      if (k == 520) begin
        n_cmp++;
        if (wr_count !== 14'd521 || busy !== 1'b1) begin
          n_err++;
          $display("FAIL trig_ignored: got wr_count=%0d busy=%b exp 521 1", wr_count, busy);
        end
      end
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (done_cnt != 1 || wr_count !== 14'd10000 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL trig_done: got pulses=%0d wr_count=%0d ready=%b exp 1 10000 1",
               done_cnt, wr_count, ready);
    end
    @(negedge DCLK);
    START_FGPA = 1'b1;
    @(negedge DCLK);
    @(negedge DCLK);
    rd_req = 1'b1;
    @(negedge DCLK);
    rd_req = 1'b0;
    START_FGPA = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0 || busy !== 1'b1 || wr_count !== 14'd0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL trig_ready_restart: got v=%b busy=%b wr_count=%0d ready=%b exp 0 1 0 0",
               rd_valid, busy, wr_count, ready);
    end
  endtask

  task automatic test_reset_restart();
    for (int k = 0; k < 500; k++) begin
      adc_valid = 1'b1;
      adc_data  = 12'hABC ^ 12'(k);
      @(negedge DCLK);
    end
    adc_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge DCLK);
    rst_n = 1'b1;
    @(negedge DCLK);
    n_cmp++;
    if (busy !== 1'b0 || wr_count !== 14'd0 || ready !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_capture: got busy=%b wr_count=%0d ready=%b exp 0 0 0",
               busy, wr_count, ready);
    end
    trigger();
    for (int k = 0; k < DEPTH; k++) begin
      adc_valid = 1'b1;
      adc_data  = 12'(k * 7 + 3);
      model[k]  = 12'(k * 7 + 3);
      @(negedge DCLK);
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (wr_count !== 14'd10000 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL restart_done: got wr_count=%0d ready=%b exp 10000 1", wr_count, ready);
    end
    for (int i = 0; i < DEPTH; i++) begin
      rd_req = 1'b1;
      @(negedge DCLK);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== {4'b0, model[i]}) begin
        n_err++;
        $display("FAIL restart_read[%0d]: got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, {4'b0, model[i]});
      end
    end
    rd_req = 1'b0;
    n_cmp++;
    if (ready !== 1'b0) begin
      n_err++;
      $display("FAIL restart_ready_drop: got %b exp 0", ready);
    end
    @(negedge DCLK);
  endtask

  task automatic test_sparse();
    int done_cnt;
    int cyc;
    done_cnt = 0;
    cyc = 0;
    trigger();
    for (int k = 0; k < DEPTH; k++) begin
      repeat (2) begin
        adc_valid = 1'b0;
        adc_data  = 12'hFFF;
        @(negedge DCLK);
        cyc++;
      end
      adc_valid = 1'b1;
      adc_data  = 12'(k + 7);
      model[k]  = 12'(k + 7);
      @(negedge DCLK);
      cyc++;
      if (capture_done === 1'b1) done_cnt++;
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (done_cnt != 1 || cyc != 3 * DEPTH || wr_count !== 14'd10000 || ready !== 1'b1) begin
      n_err++;
      $display("FAIL sparse_done: got pulses=%0d cyc=%0d wr_count=%0d ready=%b exp 1 30000 10000 1",
               done_cnt, cyc, wr_count, ready);
    end
    for (int i = 0; i < 64; i++) begin
      rd_req = 1'b1;
      @(negedge DCLK);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== {4'b0, model[i]}) begin
        n_err++;
        $display("FAIL sparse_read[%0d]: got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, {4'b0, model[i]});
      end
    end
    rd_req = 1'b0;
    START_FGPA = 1'b1;
    @(negedge DCLK);
    n_cmp++;
    if (rd_valid !== 1'b0 || rd_data !== 16'h0046) begin
      n_err++;
      $display("FAIL sparse_hold: got v=%b d=%h exp 0 0046", rd_valid, rd_data);
    end
    repeat (4) @(negedge DCLK);
    START_FGPA = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || ready !== 1'b1 || wr_count !== 14'd10000) begin
      n_err++;
      $display("FAIL readout_trig_ignored: got busy=%b ready=%b wr_count=%0d exp 0 1 10000",
               busy, ready, wr_count);
    end
  endtask
`else
  task automatic test_avg();
    logic [DATA_W-1:0] vin [12];
    logic [DATA_W-1:0] vexp [3];
    vin  = '{12'd1, 12'd2, 12'd3, 12'd6, 12'd4095, 12'd4095, 12'd4095, 12'd4095,
             12'd0, 12'd0, 12'd0, 12'd3};
    vexp = '{12'd3, 12'd4095, 12'd0};
    trigger();
    for (int k = 0; k < 4 * DEPTH; k++) begin
      adc_valid = 1'b1;
      adc_data  = (k < 12) ? vin[k] : 12'd0;
      @(negedge DCLK);
      if (k == 3) begin
        n_cmp++;
        if (wr_count !== 14'd1) begin
          n_err++;
          $display("FAIL avg_wr_count: got %0d exp 1", wr_count);
        end
      end
    end
    adc_valid = 1'b0;
    n_cmp++;
    if (capture_done !== 1'b1 || wr_count !== 14'd10000) begin
      n_err++;
      $display("FAIL avg_done: got done=%b wr_count=%0d exp 1 10000", capture_done, wr_count);
    end
    for (int i = 0; i < 3; i++) begin
      rd_req = 1'b1;
      @(negedge DCLK);
      n_cmp++;
      if (rd_valid !== 1'b1 || rd_data !== {4'b0, vexp[i]}) begin
        n_err++;
        $display("FAIL avg_read[%0d]: got v=%b d=%h exp 1 %h", i, rd_valid, rd_data, {4'b0, vexp[i]});
      end
    end
    rd_req = 1'b0;
    @(negedge DCLK);
  endtask
`endif

  initial begin
    test_reset();
`ifdef ADC_CAPTURE_AVG_EN
    test_avg();
`else
    test_ramp();
    test_trigger();
    test_reset_restart();
    test_sparse();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/adc_capture_buffer.md
# adc_capture_buffer

Captures a fixed-length burst of 12-bit ADC samples into on-chip RAM on a start trigger, then serves them one word per read request to the FSMC readout stage. Sits directly upstream of the FSMC interface block in the DCLK domain. Replaces the static test pattern table with live acquisition data. Output words are zero-extended to the 16-bit FSMC bus width.

## Interface
- DEPTH, 10000: samples stored per burst.
- DATA_W, 12: ADC sample width.
- ADDR_W, 14: address width; must satisfy 2^ADDR_W ≥ DEPTH.
- AVG_LOG2, 2: log2 of the averaging block size; used only when ADC_CAPTURE_AVG_EN is defined.
- DCLK  input  1  sole clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- START_FGPA  input  1  asynchronous capture trigger, level input.
- adc_data  input  DATA_W  sample, synchronous to DCLK.
- adc_valid  input  1  adc_data qualifier, one sample per high cycle.
- rd_req  input  1  one-cycle read strobe from the FSMC stage.
- rd_data  output  16  {4'b0, sample}.
- rd_valid  output  1  rd_data valid, one-cycle pulse.
- busy  output  1  high in CAPTURE.
- ready  output  1  high in READY and READOUT.
- capture_done  output  1  one-cycle pulse when the last sample is written.
- wr_count  output  ADDR_W  samples stored in the current burst.

## Operation
- START_FGPA passes through a 2-flop synchronizer plus a previous-value flop. A trigger is sync[1]=1 and prev=0.
- FSM states:
  - IDLE –trigger→ CAPTURE.
  - CAPTURE –last write→ READY.
  - READY –first accepted rd_req→ READOUT.
  - READOUT –read of address DEPTH-1→ IDLE.
  - READY –trigger→ CAPTURE. This restarts the burst, discards prior data and resets wr_count to 0.
- A trigger in CAPTURE or READOUT is ignored.
- Write path in CAPTURE: each stored sample is written at wr_addr, then wr_addr increments. The write at address DEPTH-1 asserts capture_done and moves the FSM to READY. There is no wrap.
- Read path: rd_req is accepted only in READY or READOUT.
  - An accepted request reads RAM at rd_addr, then rd_addr increments.
  - rd_req in IDLE or CAPTURE is ignored and produces no rd_valid.
- Simultaneous trigger and rd_req in READY: the trigger wins and the read is dropped.
- Reset, including mid-capture or mid-readout, forces IDLE and zeros wr_addr, rd_addr and the accumulator. RAM contents are left unchanged but are undefined to the consumer.
- Reset values: rd_data=0, rd_valid=0, busy=0, ready=0, capture_done=0, wr_count=0.

## Timing
- Trigger latency: the START_FGPA rising edge is seen by the detector 2 DCLK cycles later. The FSM enters CAPTURE on the following edge.
- The first adc_valid cycle in which the FSM is in CAPTURE supplies sample 0.
- wr_count updates in the cycle after each write.
- ready rises in the same cycle as the capture_done pulse.
- Read latency is 1 cycle: rd_req at cycle n gives rd_valid and rd_data at n+1. rd_data holds its value until the next accepted read.
- Back-to-back rd_req every cycle is supported at full throughput.
- The FSM returns to IDLE in the cycle after the read of address DEPTH-1 is accepted. ready drops then. The rd_valid for that last read still occurs.

## Configuration
- ADC_CAPTURE_AVG_EN defined: valid samples are accumulated in a (DATA_W+AVG_LOG2)-bit accumulator. Every 2^AVG_LOG2-th valid sample, (sum >> AVG_LOG2) is stored, truncated with no rounding, and the accumulator clears. A burst therefore consumes DEPTH·2^AVG_LOG2 valid samples.
- ADC_CAPTURE_AVG_EN undefined: every valid sample is stored raw. No accumulator is built.

## Structure
- Package adc_capture_pkg holds:
  - the state enum (IDLE, CAPTURE, READY, READOUT);
  - default DEPTH, DATA_W and ADDR_W constants;
  - the output pad width constant OUT_W=16.
- Sub-module adc_capture_ram: a simple dual-port inferred block RAM with one write port and a registered read port, DEPTH×DATA_W.

## Test plan
- Reset: assert rst_n=0 mid-operation, then release → all outputs 0. rd_req pulses produce no rd_valid.
- Ramp capture: trigger, then adc_valid held high with adc_data=k mod 4096 for k=0..9999 → one capture_done pulse, wr_count=10000, ready=1. 10000 rd_req give rd_data=k mod 4096, each one cycle after its request. ready=0 after the last read.
- Sparse valid: adc_valid every 3rd cycle with values 7, 8, 9… → RAM holds 7, 8, 9… contiguously. Capture takes about 3·DEPTH cycles.
- Trigger handling: a second trigger at sample 500 is ignored, and capture completes normally. A trigger in READY restarts capture, and wr_count returns to 0. A trigger coinciding with rd_req in READY gives no rd_valid.
- Reset mid-capture at sample 500, then a new trigger → capture restarts at address 0, and readout matches only the new data.
- With ADC_CAPTURE_AVG_EN and AVG_LOG2=2: inputs 1, 2, 3, 6 → stored 3. Inputs 4095×4 → stored 4095. Inputs 0, 0, 0, 3 → stored 0.
